collision_score: RTL and testbench

COLLISION_SCORE -- requirements
Module: collision_score

---
 rtl/collision_score.sv | 165 ++++++++++++++++
 tb/tb_collision_score.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_score.sv
// rtl/collision_score.sv - game-state FSM with collision detection and BCD scoring
//
// Purpose : Runs the IDLE/PLAY/HIT/OVER game loop. Each physics strobe
//           tests the bird box against the pipe and the floor, and
//           counts points reported by the pipe generator.
// Optional: HIGH_SCORE_EN macro adds the best-score register; without it
//           o_hiscore is tied to 000.
// Ports   : i_clk, i_rst_n (async active-low), i_physics_stb, i_start,
//           i_p_x1/x2/y1/y2 (pipe), i_b_x1/x2/y1/y2 (bird), i_point_add,
//           o_state, o_score, o_hiscore, o_collide, o_freeze.
module collision_score #(
    parameter int D_HEIGHT = 480,
    parameter int HIT_HOLD = 60
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_physics_stb,
    input  logic        i_start,
    input  logic [11:0] i_p_x1,
    input  logic [11:0] i_p_x2,
    input  logic [11:0] i_p_y1,
    input  logic [11:0] i_p_y2,
    input  logic [11:0] i_b_x1,
    input  logic [11:0] i_b_x2,
    input  logic [11:0] i_b_y1,
    input  logic [11:0] i_b_y2,
    input  logic        i_point_add,
    output logic [1:0]  o_state,
    output logic [11:0] o_score,
    output logic [11:0] o_hiscore,
    output logic        o_collide,
    output logic        o_freeze
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_HIT  = 2'd2,
        S_OVER = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] score_q, score_d;
    logic [7:0]  hold_q, hold_d;
    logic        collide_q, collide_d;
    logic        start_q;

    logic start_edge;
    logic x_ov, y_out, floor_hit, hit;

    // Three-digit BCD increment; 999 rolls over to 000.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [3:0] d2, d1, d0;
        d2 = v[11:8];
        d1 = v[7:4];
        d0 = v[3:0];
        if (d0 == 4'd9) begin
            d0 = 4'd0;
            if (d1 == 4'd9) begin
                d1 = 4'd0;
                d2 = (d2 == 4'd9) ? 4'd0 : d2 + 4'd1;
            end else begin
                d1 = d1 + 4'd1;
            end
        end else begin
            d0 = d0 + 4'd1;
        end
        return {d2, d1, d0};
    endfunction

    assign start_edge = i_start & ~start_q;

    assign x_ov      = (i_b_x2 > i_p_x1) && (i_b_x1 < i_p_x2);
    assign y_out     = (i_b_y1 < i_p_y1) || (i_b_y2 > i_p_y2);
    assign floor_hit = (i_b_y2 >= 12'(D_HEIGHT));
    assign hit       = (x_ov && y_out) || floor_hit;

    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        hold_d    = hold_q;
        collide_d = collide_q;
        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_d   = S_PLAY;
                    score_d   = 12'h000;
                    collide_d = 1'b0;
                end
            end
            S_PLAY: begin
                if (i_physics_stb) begin
                    collide_d = hit;
                    // A collision on the same strobe as a point wins.
                    if (hit) begin
                        state_d = S_HIT;
                        hold_d  = 8'(HIT_HOLD);
                    end else if (i_point_add) begin
                        score_d = bcd_inc(score_q);
                    end
                end
            end
            S_HIT: begin
                if (i_physics_stb) begin
                    hold_d = hold_q - 8'd1;
                    if (hold_q == 8'd1) begin
                        state_d = S_OVER;
                    end
                end
            end
            S_OVER: begin
                if (start_edge) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            score_q   <= 12'h000;
            hold_q    <= 8'd0;
            collide_q <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            hold_q    <= hold_d;
            collide_q <= collide_d;
            start_q   <= i_start;
        end
    end

`ifdef HIGH_SCORE_EN
    logic [11:0] hiscore_q, hiscore_d;

    // BCD digits order the same way as plain binary, so an unsigned compare suffices.
    always_comb begin
        hiscore_d = hiscore_q;
        if (state_q == S_HIT && state_d == S_OVER && score_q > hiscore_q) begin
            hiscore_d = score_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hiscore_q <= 12'h000;
        end else begin
            hiscore_q <= hiscore_d;
        end
    end

    assign o_hiscore = hiscore_q;
`else
    assign o_hiscore = 12'h000;
`endif

    assign o_state   = state_q;
    assign o_score   = score_q;
    assign o_collide = collide_q;
    assign o_freeze  = (state_q != S_PLAY);

endmodule

// File: tb/tb_collision_score.sv
// tb/tb_collision_score.sv - randomized self-checking bench for collision_score
module tb_collision_score;

    localparam int HOLD = 3;
`ifdef HIGH_SCORE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb, start, padd;
    logic [11:0] p_x1, p_x2, p_y1, p_y2, b_x1, b_x2, b_y1, b_y2;
    logic [1:0]  st;
    logic [11:0] score, hiscore;
    logic        collide, freeze;

    int vectors = 0;
    int miscompares = 0;

    // reference model state: plain integers, score kept in decimal
    int m_state, m_score, m_hi, m_collide, m_hold, m_sprev;

    collision_score #(.D_HEIGHT(480), .HIT_HOLD(HOLD)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_physics_stb(stb), .i_start(start),
        .i_p_x1(p_x1), .i_p_x2(p_x2), .i_p_y1(p_y1), .i_p_y2(p_y2),
        .i_b_x1(b_x1), .i_b_x2(b_x2), .i_b_y1(b_y1), .i_b_y2(b_y2),
        .i_point_add(padd), .o_state(st), .o_score(score), .o_hiscore(hiscore),
        .o_collide(collide), .o_freeze(freeze)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] to_bcd(input int n);
        logic [11:0] r;
        r[11:8] = 4'(n / 100);
        r[7:4]  = 4'((n / 10) % 10);
        r[3:0]  = 4'(n % 10);
        return r;
    endfunction

    task automatic model_reset();
        m_state = 0; m_score = 0; m_hi = 0; m_collide = 0; m_hold = 0; m_sprev = 0;
    endtask

    // Advance the model from the current inputs, then clock the DUT; returns at edge+1.
    task automatic tick();
        int se, hit;
        se  = (start && !m_sprev) ? 1 : 0;
        hit = (((int'(b_x2) > int'(p_x1)) && (int'(b_x1) < int'(p_x2)) &&
                ((int'(b_y1) < int'(p_y1)) || (int'(b_y2) > int'(p_y2)))) ||
               (int'(b_y2) >= 480)) ? 1 : 0;
        case (m_state)
            0: if (se != 0) begin m_state = 1; m_score = 0; m_collide = 0; end
            1: if (stb) begin
                m_collide = hit;
                if (hit != 0) begin m_state = 2; m_hold = HOLD; end
                else if (padd) m_score = (m_score + 1) % 1000;
            end
            2: if (stb) begin
                if (m_hold == 1) begin
                    m_state = 3;
                    if (HS && m_score > m_hi) m_hi = m_score;
                end
                m_hold = m_hold - 1;
            end
            default: if (se != 0) m_state = 0;
        endcase
        m_sprev = start;
        @(posedge clk);
        #1;
    endtask

    task automatic press();
        start = 1'b1; tick();
        start = 1'b0; tick();
    endtask

    task automatic safe_geom();
        p_x1 = 12'd300; p_x2 = 12'd350; p_y1 = 12'd100; p_y2 = 12'd400;
        b_x1 = 12'd10;  b_x2 = 12'd30;  b_y1 = 12'd200; b_y2 = 12'd220;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stb = 0; start = 0; padd = 0;
        safe_geom();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (st !== 2'd0 || score !== 12'h000 || hiscore !== 12'h000 || collide !== 1'b0 || freeze !== 1'b1) begin
            miscompares++;
            $display("FAIL reset: state=%0d score=%h hi=%h col=%b frz=%b, want 0 000 000 0 1", st, score, hiscore, collide, freeze);
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (st !== 2'd0) begin
            miscompares++;
            $display("FAIL idle_hold: state=%0d want 0", st);
        end
    endtask

    task automatic test_start();
        start = 1'b1; tick();
        vectors++;
        if (st !== 2'd1 || score !== 12'h000 || freeze !== 1'b0) begin
            miscompares++;
            $display("FAIL start: state=%0d score=%h frz=%b, want 1 000 0", st, score, freeze);
        end
        tick();
        vectors++;
        if (st !== 2'd1) begin
            miscompares++;
            $display("FAIL start_held: state=%0d want 1", st);
        end
        start = 1'b0; tick();
        start = 1'b1; tick();
        vectors++;
        if (st !== 2'd1 || score !== 12'h000) begin
            miscompares++;
            $display("FAIL start_in_play: state=%0d score=%h, want 1 000", st, score);
        end
        start = 1'b0; tick();
    endtask

    task automatic test_points();
        for (int i = 0; i < 12; i++) begin
            stb = 1; padd = 1; tick();
            stb = 0; tick();
            padd = 0; tick();
        end
        vectors++;
        if (score !== 12'h012 || score !== to_bcd(m_score)) begin
            miscompares++;
            $display("FAIL score12: got %h want 012 (model %h)", score, to_bcd(m_score));
        end
        stb = 1; padd = 1;
        for (int i = 0; i < 987; i++) tick();
        vectors++;
        if (score !== 12'h999) begin
            miscompares++;
            $display("FAIL score999: got %h want 999", score);
        end
        tick();
        stb = 0; padd = 0;
        vectors++;
        if (score !== 12'h000 || st !== 2'd1) begin
            miscompares++;
            $display("FAIL wrap: score=%h state=%0d, want 000 1", score, st);
        end
    endtask

    task automatic test_collide();
        b_x1 = 12'd100; b_x2 = 12'd120; b_y1 = 12'd200; b_y2 = 12'd220;
        p_x1 = 12'd90;  p_x2 = 12'd250; p_y1 = 12'd230; p_y2 = 12'd470;
        tick();
        vectors++;
        if (collide !== 1'b0 || st !== 2'd1) begin
            miscompares++;
            $display("FAIL no_strobe_hit: col=%b state=%0d, want 0 1", collide, st);
        end
        stb = 1; padd = 1; tick();
        stb = 0; padd = 0;
        vectors++;
        if (collide !== 1'b1 || st !== 2'd2 || score !== 12'h000 || freeze !== 1'b1) begin
            miscompares++;
            $display("FAIL hit: col=%b state=%0d score=%h frz=%b, want 1 2 000 1", collide, st, score, freeze);
        end
        for (int i = 0; i < HOLD; i++) begin
            vectors++;
            if (st !== 2'd2) begin
                miscompares++;
                $display("FAIL hold%0d: state=%0d want 2", i, st);
            end
            stb = 1; tick(); stb = 0; tick();
        end
        vectors++;
        if (st !== 2'd3) begin
            miscompares++;
            $display("FAIL over: state=%0d want 3", st);
        end
        press();
        vectors++;
        if (st !== 2'd0 || score !== 12'h000) begin
            miscompares++;
            $display("FAIL to_idle: state=%0d score=%h, want 0 000", st, score);
        end
    endtask

    task automatic test_over_hiscore();
        logic [11:0] want_hi;
        press();
        vectors++;
        if (st !== 2'd1 || collide !== 1'b0) begin
            miscompares++;
            $display("FAIL replay: state=%0d col=%b, want 1 0", st, collide);
        end
        safe_geom();
        stb = 1; padd = 1;
        for (int i = 0; i < 41; i++) tick();
        stb = 0; padd = 0;
        b_x1 = 12'd100; b_x2 = 12'd120; b_y1 = 12'd200; b_y2 = 12'd220;
        p_x1 = 12'd90;  p_x2 = 12'd250; p_y1 = 12'd230; p_y2 = 12'd470;
        stb = 1; padd = 1; tick();
        stb = 0; padd = 0;
        vectors++;
        if (st !== 2'd2 || score !== 12'h041) begin
            miscompares++;
            $display("FAIL hit_vs_point: state=%0d score=%h, want 2 041", st, score);
        end
        start = 1; stb = 1; tick();
        start = 0; tick(); tick();
        stb = 0;
        want_hi = HS ? 12'h041 : 12'h000;
        vectors++;
        if (st !== 2'd3 || hiscore !== want_hi || score !== 12'h041) begin
            miscompares++;
            $display("FAIL hiscore: state=%0d hi=%h score=%h, want 3 %h 041", st, hiscore, score, want_hi);
        end
        press();
        vectors++;
        if (st !== 2'd0 || score !== 12'h041) begin
            miscompares++;
            $display("FAIL over_idle: state=%0d score=%h, want 0 041", st, score);
        end
    endtask

    task automatic test_floor_reset();
        press();
        b_x1 = 12'd10; b_x2 = 12'd30; b_y1 = 12'd460; b_y2 = 12'd480;
        p_x1 = 12'd300; p_x2 = 12'd350; p_y1 = 12'd100; p_y2 = 12'd400;
        stb = 1; tick(); stb = 0; tick();
        vectors++;
        if (st !== 2'd2) begin
            miscompares++;
            $display("FAIL floor: state=%0d want 2", st);
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (st !== 2'd0 || hiscore !== 12'h000 || score !== 12'h000 || collide !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: state=%0d hi=%h score=%h col=%b, want 0 000 000 0", st, hiscore, score, collide);
        end
        #1 rst_n = 1'b1;
        safe_geom();
        tick();
        vectors++;
        if (st !== 2'd0) begin
            miscompares++;
            $display("FAIL post_reset: state=%0d want 0", st);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            p_x1 = 12'($urandom_range(0, 300));
            p_x2 = p_x1 + 12'($urandom_range(0, 200));
            p_y1 = 12'($urandom_range(0, 300));
            p_y2 = p_y1 + 12'($urandom_range(0, 250));
            b_x1 = 12'($urandom_range(0, 500));
            b_x2 = b_x1 + 12'd20;
            b_y1 = 12'($urandom_range(0, 470));
            b_y2 = b_y1 + 12'd20;
            if ($urandom_range(0, 3) != 0) safe_geom();
            stb   = ($urandom_range(0, 1) == 1);
            padd  = ($urandom_range(0, 1) == 1);
            start = ($urandom_range(0, 3) == 0);
            tick();
            vectors++;
            if (st !== 2'(m_state) || score !== to_bcd(m_score) || hiscore !== to_bcd(m_hi) ||
                collide !== 1'(m_collide) || freeze !== (m_state != 1)) begin
                miscompares++;
                $display("FAIL random%0d: st=%0d sc=%h hi=%h col=%b frz=%b, want %0d %h %h %0d %0d",
                         i, st, score, hiscore, collide, freeze, m_state, to_bcd(m_score),
                         to_bcd(m_hi), m_collide, (m_state != 1));
            end
        end
        stb = 0; padd = 0; start = 0;
    endtask

    initial begin
        test_reset();
        test_start();
        test_points();
        test_collide();
        test_over_hiscore();
        test_floor_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
